// File: rtl/dbus_pkg.sv
// Shared types and defaults for the cpu data-bus bridge and its posted-write buffer.
package dbus_pkg;

  localparam int DADDRWIDTH_DEF = 16;
  localparam int DWIDTH_DEF     = 16;
  localparam int WBUF_DEPTH_DEF = 4;

  typedef struct packed {
    logic [DADDRWIDTH_DEF-1:0] addr;
    logic [DWIDTH_DEF-1:0]     data;
  } wbuf_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
    return (en && value != 16'hFFFF) ? value + 16'd1 : value;
  endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// cpu data port plus SRAM port bundle; slave = bridge view, master = cpu/SRAM side.
interface dbus_bridge_if import dbus_pkg::*; #(
  parameter int AW = DADDRWIDTH_DEF,
  parameter int DW = DWIDTH_DEF
);
  logic [AW-1:0] raddr;
  logic          re;
  logic [DW-1:0] rdata;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  raddr, re, waddr, wdata, we, mem_rdata,
    output rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output raddr, re, waddr, wdata, we, mem_rdata,
    input  rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dbus_wbuf.sv
// Posted-write FIFO with a combinational youngest-match lookup for read forwarding.
module dbus_wbuf import dbus_pkg::*; #(
  parameter int DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wbuf_entry_t               push_entry,
  input  logic                      pop,
  input  logic [DADDRWIDTH_DEF-1:0] lookup_addr,
  output wbuf_entry_t               head_entry,
  output logic                      full,
  output logic                      empty,
  output logic                      hit,
  output logic [DWIDTH_DEF-1:0]     hit_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = DEPTH + 1;

  wbuf_entry_t   store [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // NOTE: the storage array has no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) store[tail] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = store[head];

  // Walk oldest to youngest so the last live match (the youngest) wins.
  // NOTE: outputs get defaults before the loop so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && store[head + PW'(k)].addr == lookup_addr) begin
        hit      = 1'b1;
        hit_data = store[head + PW'(k)].data;
      end
    end
  end

endmodule

// File: rtl/dbus_bridge.sv
// cpu data bus to single-port SRAM bridge: reads win the port, writes are posted and forwarded.
// Optional statistics counters are enabled by defining DBUS_BRIDGE_STATS_EN.
module dbus_bridge import dbus_pkg::*; #(
  parameter int DADDRWIDTH = DADDRWIDTH_DEF,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  dbus_bridge_if.slave     bus,
  output logic             wbuf_full,
  output logic             wbuf_empty,
  output logic             overflow
`ifdef DBUS_BRIDGE_STATS_EN
  ,
  output logic [15:0]      stat_fwd_hits,
  output logic [15:0]      stat_drain_stalls,
  output logic [15:0]      stat_writes
`endif
);
  wbuf_entry_t           head;
  logic                  lk_hit;
  logic [DWIDTH_DEF-1:0] lk_data;
  logic                  accept_wr;
  logic                  drain;
  logic                  rd_pend_q;
  logic                  fwd_hit_q;
  logic [DWIDTH-1:0]     fwd_data_q;
  logic [DWIDTH-1:0]     rdata_q;
  logic [DWIDTH-1:0]     rdata_now;

  // A write to a full buffer only fits when this cycle's drain frees the head slot.
  assign accept_wr = bus.we & ~(wbuf_full & bus.re);
  assign drain     = ~bus.re & ~wbuf_empty;

  dbus_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (accept_wr),
    .push_entry  ('{addr: DADDRWIDTH_DEF'(bus.waddr), data: DWIDTH_DEF'(bus.wdata)}),
    .pop         (drain),
    .lookup_addr (DADDRWIDTH_DEF'(bus.raddr)),
    .head_entry  (head),
    .full        (wbuf_full),
    .empty       (wbuf_empty),
    .hit         (lk_hit),
    .hit_data    (lk_data)
  );

  assign bus.mem_re    = bus.re;
  assign bus.mem_we    = drain;
  assign bus.mem_addr  = bus.re ? bus.raddr : DADDRWIDTH'(head.addr);
  assign bus.mem_wdata = DWIDTH'(head.data);

  assign rdata_now = fwd_hit_q ? fwd_data_q : bus.mem_rdata;
  assign bus.rdata = rd_pend_q ? rdata_now : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      rdata_q    <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_pend_q <= bus.re;
      if (bus.re) begin
        fwd_hit_q  <= lk_hit;
        fwd_data_q <= DWIDTH'(lk_data);
      end
      if (rd_pend_q) rdata_q <= rdata_now;
      if (bus.we && bus.re && wbuf_full) overflow <= 1'b1;
    end
  end

`ifdef DBUS_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_hits     <= '0;
      stat_drain_stalls <= '0;
      stat_writes       <= '0;
    end else begin
      stat_fwd_hits     <= sat_inc16(stat_fwd_hits, bus.re & lk_hit);
      stat_drain_stalls <= sat_inc16(stat_drain_stalls, bus.re & ~wbuf_empty);
      stat_writes       <= sat_inc16(stat_writes, accept_wr);
    end
  end
`endif

endmodule

// File: tb/tb_dbus_bridge.sv
// Scoreboard bench for dbus_bridge: directed scenarios then random traffic against an architectural model.
module tb_dbus_bridge;
  import dbus_pkg::*;

  localparam int DEPTH = WBUF_DEPTH_DEF;

  typedef struct {
    bit mre;
    bit mwe;
    bit full;
    bit empty;
    bit ovf;
  } cyc_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sram_init = 1'b1;
  always #5 clk = ~clk;

  dbus_bridge_if bus ();
  logic wbuf_full, wbuf_empty, overflow;
`ifdef DBUS_BRIDGE_STATS_EN
  logic [15:0] stat_fwd_hits, stat_drain_stalls, stat_writes;
`endif

  dbus_bridge dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .wbuf_full         (wbuf_full),
    .wbuf_empty        (wbuf_empty),
    .overflow          (overflow)
`ifdef DBUS_BRIDGE_STATS_EN
    ,
    .stat_fwd_hits     (stat_fwd_hits),
    .stat_drain_stalls (stat_drain_stalls),
    .stat_writes       (stat_writes)
`endif
  );

  // Environment SRAM: 256 words, synchronous read with 1-cycle latency.
  logic [15:0] sram [256];
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h0100 + 16'(i * 3);
    end else begin
      if (bus.mem_we) sram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr[7:0]];
    end
  end

  // Reference model: SRAM image, pending posted writes, expected traffic queues.
  logic [15:0] img [256];
  wbuf_entry_t pend [$];
  wbuf_entry_t exp_wr [$];
  logic [15:0] exp_rd [$];
  cyc_exp_t    cyc_q [$];
  bit          m_ovf;
  int          m_hits, m_stalls, m_writes;
  int          total = 0;
  int          bad = 0;
  bit          prev_re = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a, output bit from_buf);
    from_buf = 1'b0;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].addr == a) begin
        from_buf = 1'b1;
        return pend[i].data;
      end
    end
    return img[a[7:0]];
  endfunction

  task automatic cyc(input bit re, input logic [15:0] ra, input bit we,
                     input logic [15:0] wa, input logic [15:0] wd);
    cyc_exp_t    e;
    int          sz;
    bit          fb;
    wbuf_entry_t ent;
    @(posedge clk);
    #1;
    bus.re = re; bus.raddr = ra; bus.we = we; bus.waddr = wa; bus.wdata = wd;
    sz = pend.size();
    e.mre = re; e.mwe = !re && sz > 0; e.full = (sz == DEPTH); e.empty = (sz == 0); e.ovf = m_ovf;
    cyc_q.push_back(e);
    if (re) begin
      exp_rd.push_back(model_read(ra, fb));
      if (fb) m_hits++;
      if (sz > 0) m_stalls++;
    end else if (sz > 0) begin
      ent = pend.pop_front();
      img[ent.addr[7:0]] = ent.data;
    end
    if (we) begin
      if (sz == DEPTH && re) m_ovf = 1'b1;
      else begin
        ent.addr = wa; ent.data = wd;
        pend.push_back(ent);
        exp_wr.push_back(ent);
        m_writes++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.re = 1'b0; bus.we = 1'b0;
    pend.delete(); exp_wr.delete(); exp_rd.delete(); cyc_q.delete();
    m_ovf = 1'b0; m_hits = 0; m_stalls = 0; m_writes = 0;
    #2;
    check("rst_empty", wbuf_empty, 1);
    check("rst_full", wbuf_full, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    cyc_exp_t    e;
    wbuf_entry_t w;
    if (!rst_n) begin
      prev_re <= 1'b0;
    end else begin
      if (prev_re) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rdata", bus.rdata, exp_rd.pop_front());
      end
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("mem_re", bus.mem_re, e.mre);
        check("mem_we", bus.mem_we, e.mwe);
        check("wbuf_full", wbuf_full, e.full);
        check("wbuf_empty", wbuf_empty, e.empty);
        check("overflow", overflow, e.ovf);
      end
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("drain_addr", bus.mem_addr, w.addr);
          check("drain_data", bus.mem_wdata, w.data);
        end
      end
      prev_re <= bus.re;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rp;
    bus.re = 1'b0; bus.we = 1'b0; bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
    m_ovf = 1'b0; m_hits = 0; m_stalls = 0; m_writes = 0;
    for (int i = 0; i < 256; i++) img[i] = 16'h0100 + 16'(i * 3);
    repeat (2) @(posedge clk);
    #1;
    sram_init = 1'b0;
    check("init_empty", wbuf_empty, 1);
    check("init_rdata", bus.rdata, 0);
    rst_n = 1'b1;

    // Posted write then read: forwarded before drain.
    cyc(1'b0, 16'h0, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    idle(3);

    // Youngest match with drain blocked by reads.
    cyc(1'b1, 16'h0050, 1'b1, 16'h0020, 16'h1111);
    cyc(1'b1, 16'h0051, 1'b1, 16'h0020, 16'h2222);
    cyc(1'b1, 16'h0020, 1'b0, 16'h0, 16'h0);
    idle(4);
    @(negedge clk);
    check("sram_0020", sram[8'h20], 16'h2222);

    // Read priority over two buffered entries.
    cyc(1'b1, 16'h0060, 1'b1, 16'h0040, 16'h4040);
    cyc(1'b1, 16'h0061, 1'b1, 16'h0041, 16'h4141);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0062 + 16'(i), 1'b0, 16'h0, 16'h0);
    idle(3);

    // Simultaneous read and write of the same address.
    cyc(1'b0, 16'h0, 1'b1, 16'h0030, 16'h00AA);
    idle(3);
    cyc(1'b1, 16'h0030, 1'b1, 16'h0030, 16'h1234);
    cyc(1'b1, 16'h0030, 1'b0, 16'h0, 16'h0);
    idle(3);

    // Full buffer: accepted with drain, dropped with read.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'h0001, 1'b1, 16'h0070 + 16'(i), 16'hA000 + 16'(i));
    cyc(1'b0, 16'h0, 1'b1, 16'h0074, 16'hA004);
    cyc(1'b1, 16'h0072, 1'b1, 16'h0075, 16'hA005);
    cyc(1'b1, 16'h0075, 1'b0, 16'h0, 16'h0);
    idle(DEPTH + 2);

`ifdef DBUS_BRIDGE_STATS_EN
    @(negedge clk);
    check("stat_writes", stat_writes, 16'(m_writes));
    check("stat_fwd_hits", stat_fwd_hits, 16'(m_hits));
    check("stat_drain_stalls", stat_drain_stalls, 16'(m_stalls));
`endif

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 16'h0080 + 16'(i), 16'hC000 + 16'(i));
    do_reset();
    idle(4);

    // Random traffic with alternating read pressure.
    for (int n = 0; n < 600; n++) begin
      rp = ((n / 50) % 2 == 0) ? 70 : 20;
      cyc(($urandom_range(0, 99) < rp), 16'h0090 + 16'($urandom_range(0, 15)),
          ($urandom_range(0, 99) < 55), 16'h0090 + 16'($urandom_range(0, 15)),
          16'($urandom));
    end
    idle(DEPTH + 3);
    @(negedge clk);
    #1;
    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
`ifdef DBUS_BRIDGE_STATS_EN
    check("stat_writes_end", stat_writes, 16'(m_writes));
    check("stat_fwd_hits_end", stat_fwd_hits, 16'(m_hits));
    check("stat_drain_stalls_end", stat_drain_stalls, 16'(m_stalls));
`endif
    for (int i = 0; i < 256; i++) check("sram_image", sram[i], img[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
